// File: rtl/strassen_sequencer_if.sv
// Handshake and control bundle between the Strassen sequencer and its datapath/consumer.
// master: the sequencer; slave: the side that issues jobs and consumes control.
interface strassen_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             result_ready;
  logic             busy;
  logic             result_valid;
  logic [1:0]       alu1Op;
  logic [1:0]       alu2Op;
  logic [1:0]       alu3Op;
  logic [1:0]       alu4Op;
  logic [1:0]       alu5Op;
  logic [1:0]       alu6Op;
  logic [1:0]       alu7Op;
  logic             mux2Sel;
  logic [1:0]       mux3Sel;
  logic [1:0]       mux4Sel;
  logic             memWe;
  logic             memMuxCtrl;
  logic [CNT_W-1:0] job_count;

  modport master (
    input  start, abort, result_ready,
    output busy, result_valid,
    output alu1Op, alu2Op, alu3Op, alu4Op, alu5Op, alu6Op, alu7Op,
    output mux2Sel, mux3Sel, mux4Sel, memWe, memMuxCtrl, job_count
  );

  modport slave (
    output start, abort, result_ready,
    input  busy, result_valid,
    input  alu1Op, alu2Op, alu3Op, alu4Op, alu5Op, alu6Op, alu7Op,
    input  mux2Sel, mux3Sel, mux4Sel, memWe, memMuxCtrl, job_count
  );
endinterface

// File: rtl/strassen_sequencer.sv
// Job-based control sequencer for the 2x2 Strassen datapath: SUM -> MUL (stalled) -> COMB ->
// two C-storage writes -> DONE. All control outputs are registered decodes of the next state.
module strassen_sequencer #(
  parameter int unsigned PROD_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input logic                  clk,
  input logic                  reset,
  strassen_sequencer_if.master bus
);

  localparam logic [1:0] OpAdd  = 2'b00;
  localparam logic [1:0] OpSub  = 2'b01;
  localparam logic [1:0] OpMul  = 2'b10;
  localparam logic [1:0] OpPass = 2'b11;

  localparam logic [3:0] StallLoad = 4'(PROD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSum,
    StMul,
    StComb,
    StWr0,
    StWr1,
    StDone
  } state_e;

  typedef struct packed {
    logic             busy;
    logic             result_valid;
    logic [1:7][1:0]  ops;
    logic             mux2_sel;
    logic [1:0]       mux3_sel;
    logic [1:0]       mux4_sel;
    logic             mem_we;
    logic             mem_mux_ctrl;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [3:0]       stall_q, stall_d;
  logic [CNT_W-1:0] job_q, job_d;
  ctrl_t            ctrl_q;

  function automatic ctrl_t decode(input state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      StSum: begin
        c.busy = 1'b1;
        c.ops  = {OpAdd, OpAdd, OpSub, OpSub, OpAdd, OpSub, OpSub};
      end
      StMul: begin
        c.busy     = 1'b1;
        c.ops      = {7{OpMul}};
        c.mux2_sel = 1'b1;
        c.mux3_sel = 2'd1;
        c.mux4_sel = 2'd1;
      end
      StComb: begin
        c.busy     = 1'b1;
        c.ops      = {OpAdd, OpAdd, OpPass, OpPass, OpSub, OpAdd, OpAdd};
        c.mux2_sel = 1'b1;
        c.mux3_sel = 2'd2;
        c.mux4_sel = 2'd2;
      end
      StWr0, StWr1: begin
        // Selects stay at their COMB values so the M-register paths are stable during writes.
        c.busy         = 1'b1;
        c.ops          = {7{OpPass}};
        c.mux2_sel     = 1'b1;
        c.mux3_sel     = 2'd2;
        c.mux4_sel     = 2'd2;
        c.mem_we       = 1'b1;
        c.mem_mux_ctrl = (st == StWr0);
      end
      StDone: c.result_valid = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    job_d   = job_q;
    case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) state_d = StSum;
      end
      StSum: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          state_d = StMul;
          stall_d = StallLoad;
        end
      end
      StMul: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (stall_q == 4'd0) begin
          state_d = StComb;
        end else begin
          stall_d = stall_q - 4'd1;
        end
      end
      StComb: state_d = bus.abort ? StIdle : StWr0;
      // Abort here still lets the current WR0 write land; only WR1 is skipped.
      StWr0:  state_d = bus.abort ? StIdle : StWr1;
      StWr1: begin
        state_d = StDone;
        job_d   = job_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      StDone: begin
        if (bus.result_ready) state_d = (bus.start && !bus.abort) ? StSum : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      stall_q <= 4'd0;
      job_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      job_q   <= job_d;
      ctrl_q  <= decode(state_d);
    end
  end

  assign bus.busy         = ctrl_q.busy;
  assign bus.result_valid = ctrl_q.result_valid;
  assign bus.alu1Op       = ctrl_q.ops[1];
  assign bus.alu2Op       = ctrl_q.ops[2];
  assign bus.alu3Op       = ctrl_q.ops[3];
  assign bus.alu4Op       = ctrl_q.ops[4];
  assign bus.alu5Op       = ctrl_q.ops[5];
  assign bus.alu6Op       = ctrl_q.ops[6];
  assign bus.alu7Op       = ctrl_q.ops[7];
  assign bus.mux2Sel      = ctrl_q.mux2_sel;
  assign bus.mux3Sel      = ctrl_q.mux3_sel;
  assign bus.mux4Sel      = ctrl_q.mux4_sel;
  assign bus.memWe        = ctrl_q.mem_we;
  assign bus.memMuxCtrl   = ctrl_q.mem_mux_ctrl;
  assign bus.job_count    = job_q;

endmodule

// File: tb/tb_strassen_sequencer.sv
// Directed bench: DUT b (PROD_CYCLES=1, CNT_W=16) for handshake/abort/reset,
// DUT a (PROD_CYCLES=4, CNT_W=2) for the multiply stall and counter wrap.
module tb_strassen_sequencer;

  localparam int SI = 0, SS = 1, SM = 2, SC = 3, S0 = 4, S1 = 5, SD = 6;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  strassen_sequencer_if #(.CNT_W(16)) b_if ();
  strassen_sequencer_if #(.CNT_W(2))  a_if ();

  strassen_sequencer #(.PROD_CYCLES(1), .CNT_W(16)) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (b_if)
  );

  strassen_sequencer #(.PROD_CYCLES(4), .CNT_W(2)) u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (a_if)
  );

  // {busy, result_valid, alu1..7, mux2Sel, mux3Sel, mux4Sel, memWe, memMuxCtrl}
  logic [22:0] obs_b, obs_a;
  assign obs_b = {b_if.busy, b_if.result_valid, b_if.alu1Op, b_if.alu2Op, b_if.alu3Op,
                  b_if.alu4Op, b_if.alu5Op, b_if.alu6Op, b_if.alu7Op, b_if.mux2Sel,
                  b_if.mux3Sel, b_if.mux4Sel, b_if.memWe, b_if.memMuxCtrl};
  assign obs_a = {a_if.busy, a_if.result_valid, a_if.alu1Op, a_if.alu2Op, a_if.alu3Op,
                  a_if.alu4Op, a_if.alu5Op, a_if.alu6Op, a_if.alu7Op, a_if.mux2Sel,
                  a_if.mux3Sel, a_if.mux4Sel, a_if.memWe, a_if.memMuxCtrl};

  function automatic logic [22:0] ctrl_of(input int st);
    case (st)
      SS: return {1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01,
                  1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
      SM: return {1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                  1'b1, 2'b01, 2'b01, 1'b0, 1'b0};
      SC: return {1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00,
                  1'b1, 2'b10, 2'b10, 1'b0, 1'b0};
      S0: return {1'b1, 1'b0, 14'h3fff, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1};
      S1: return {1'b1, 1'b0, 14'h3fff, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0};
      SD: return {1'b0, 1'b1, 14'h0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
      default: return 23'h0;
    endcase
  endfunction

  int seq_b[6] = '{SS, SM, SC, S0, S1, SD};
  int seq_a[9] = '{SS, SM, SM, SM, SM, SC, S0, S1, SD};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b_if.start = 0; b_if.abort = 0; b_if.result_ready = 0;
    a_if.start = 0; a_if.abort = 0; a_if.result_ready = 0;

    // Reset state
    step();
    step();
    check("in_reset_ctrl", 32'(obs_b), 32'h0);
    check("in_reset_cnt", 32'(b_if.job_count), 32'h0);
    @(negedge clk);
    rst_a = 0;
    rst_b = 0;
    #1;
    check("post_reset_ctrl", 32'(obs_b), 32'(ctrl_of(SI)));
    step();
    check("idle_hold", 32'(obs_b), 32'(ctrl_of(SI)));

    // Single job, PROD_CYCLES=1: SUM at cycle 1, DONE at cycle 6
    b_if.start = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      b_if.start = 0;
      check($sformatf("job1_c%0d", i + 1), 32'(obs_b), 32'(ctrl_of(seq_b[i])));
    end
    check("job1_count", 32'(b_if.job_count), 32'd1);

    // DONE holds while result_ready is low, then back-to-back job
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("done_hold_%0d", i), 32'(obs_b), 32'(ctrl_of(SD)));
    end
    b_if.start = 1;
    b_if.result_ready = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      b_if.start = 0;
      b_if.result_ready = 0;
      check($sformatf("job2_c%0d", i + 1), 32'(obs_b), 32'(ctrl_of(seq_b[i])));
    end
    check("job2_count", 32'(b_if.job_count), 32'd2);
    b_if.result_ready = 1;
    step();
    b_if.result_ready = 0;
    check("done_to_idle", 32'(obs_b), 32'(ctrl_of(SI)));

    // abort wins over start in IDLE
    b_if.start = 1;
    b_if.abort = 1;
    step();
    b_if.start = 0;
    b_if.abort = 0;
    check("abort_prio_idle", 32'(obs_b), 32'(ctrl_of(SI)));

    // abort during MUL
    b_if.start = 1;
    step();
    b_if.start = 0;
    step();
    check("abm_mul", 32'(obs_b), 32'(ctrl_of(SM)));
    b_if.abort = 1;
    step();
    b_if.abort = 0;
    check("abm_idle", 32'(obs_b), 32'(ctrl_of(SI)));
    check("abm_count", 32'(b_if.job_count), 32'd2);

    // abort during WR0: one write with memMuxCtrl=1, then IDLE
    b_if.start = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      b_if.start = 0;
      check($sformatf("abw_c%0d", i + 1), 32'(obs_b), 32'(ctrl_of(seq_b[i])));
    end
    b_if.abort = 1;
    step();
    b_if.abort = 0;
    check("abw_idle", 32'(obs_b), 32'(ctrl_of(SI)));
    check("abw_count", 32'(b_if.job_count), 32'd2);

    // abort during WR1 is ignored
    b_if.start = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      b_if.start = 0;
    end
    check("abw1_wr1", 32'(obs_b), 32'(ctrl_of(S1)));
    b_if.abort = 1;
    step();
    b_if.abort = 0;
    check("abw1_done", 32'(obs_b), 32'(ctrl_of(SD)));
    check("abw1_count", 32'(b_if.job_count), 32'd3);
    b_if.result_ready = 1;
    step();
    b_if.result_ready = 0;

    // Asynchronous reset mid-COMB
    b_if.start = 1;
    step();
    b_if.start = 0;
    step();
    step();
    check("ar_comb", 32'(obs_b), 32'(ctrl_of(SC)));
    #2;
    rst_b = 1;
    #1;
    check("ar_ctrl", 32'(obs_b), 32'h0);
    check("ar_count", 32'(b_if.job_count), 32'h0);
    @(negedge clk);
    rst_b = 0;
    b_if.start = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      b_if.start = 0;
      check($sformatf("ar_job_c%0d", i + 1), 32'(obs_b), 32'(ctrl_of(seq_b[i])));
    end
    check("ar_job_count", 32'(b_if.job_count), 32'd1);

    // PROD_CYCLES=4, CNT_W=2: five jobs, start held high while busy
    for (int j = 0; j < 5; j++) begin
      a_if.start = 1;
      for (int i = 0; i < 9; i++) begin
        step();
        check($sformatf("a_job%0d_c%0d", j + 1, i + 1), 32'(obs_a), 32'(ctrl_of(seq_a[i])));
      end
      a_if.start = 0;
      check($sformatf("a_job%0d_count", j + 1), 32'(a_if.job_count),
            (j == 3) ? 32'd0 : ((j == 4) ? 32'd1 : 32'(j + 1)));
      a_if.result_ready = 1;
      step();
      a_if.result_ready = 0;
      check($sformatf("a_job%0d_idle", j + 1), 32'(obs_a), 32'(ctrl_of(SI)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/strassen_sequencer.md
Name: strassen_sequencer

Overview:
- Control sequencer for the 2x2 Strassen matrix-multiply datapath: seven ALUs, operand select muxes, M-register bank and the four-entry C storage.
- Replaces the free-running FSM with a start/done job handshake, a programmable multiply-stall phase, abort, and a job counter.
- Drives every ALU opcode, mux select and C-storage write control directly.

Parameters:
- PROD_CYCLES, 1, number of cycles the MUL phase is held (multiplier latency); legal range 1..15.
- CNT_W, 16, width of the completed-job counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; forces IDLE
- start  input  1  request a job; sampled in IDLE, or in DONE together with result_ready
- abort  input  1  synchronous; cancels an in-flight job
- result_ready  input  1  consumer accepts the result
- busy  output  1  high in any state except IDLE and DONE
- result_valid  output  1  high in DONE; C storage holds the new c11..c22
- alu1Op..alu7Op  output  2 each  ALU opcodes: 00 ADD, 01 SUB, 10 MUL, 11 PASS_A
- mux2Sel  output  1  1-bit operand select
- mux3Sel  output  2  4-way operand select, group A
- mux4Sel  output  2  4-way operand select, group B
- memWe  output  1  C-storage write enable
- memMuxCtrl  output  1  1 selects m1/m2 to addresses 0/3; 0 selects m3/m4 to addresses 1/2
- job_count  output  CNT_W  completed jobs, wraps modulo 2^CNT_W

Behaviour:
- Timing: Moore machine. All control outputs are decoded from the registered state and stall counter; there are no combinational input-to-output paths.
- Reset: state IDLE, stall counter 0, job_count 0. Every output is 0 while reset is high, and is valid IDLE decode immediately after reset.
- IDLE:
  - All ops 00, all selects 0, memWe 0, busy 0, result_valid 0.
  - start=1 -> SUM.
- SUM (1 cycle):
  - Ops alu1..7 = ADD, ADD, SUB, SUB, ADD, SUB, SUB.
  - mux2Sel 0, mux3Sel 0, mux4Sel 0.
  - Next state MUL; stall counter loads PROD_CYCLES-1.
- MUL (PROD_CYCLES cycles):
  - All ops MUL; mux2Sel 1, mux3Sel 1, mux4Sel 1.
  - The counter decrements each cycle; at 0 the next state is COMB.
- COMB (1 cycle):
  - Ops alu1..7 = ADD, ADD, PASS_A, PASS_A, SUB, ADD, ADD.
  - mux2Sel 1, mux3Sel 2, mux4Sel 2.
  - Next state WR0.
- WR0 (1 cycle):
  - memWe 1, memMuxCtrl 1, ops 11, selects held at COMB values.
  - Next state WR1.
- WR1 (1 cycle):
  - memWe 1, memMuxCtrl 0, ops 11, selects held.
  - Next state DONE; job_count increments on this transition.
- DONE:
  - result_valid 1, busy 0, memWe 0, ops 00, selects 0.
  - Holds until result_ready=1.
  - result_ready=1 with start=1 -> SUM (back-to-back job).
  - result_ready=1 with start=0 -> IDLE.
- Latency: start sampled at edge t0 -> SUM during cycle t0+1 -> result_valid first high in cycle t0+5+PROD_CYCLES.
- start is ignored while busy; no queuing.
- abort:
  - In SUM, MUL or COMB: next state IDLE, job_count unchanged, memWe never asserted for that job.
  - In WR0: completes WR0, goes to IDLE without WR1, job_count unchanged. C storage is then partially updated, which is acceptable.
  - In WR1: ignored; the job completes.
  - In IDLE or DONE: no effect. abort has priority over start in the same cycle.
- memWe: high for exactly two consecutive cycles per completed job, with memMuxCtrl 1 then 0. It is never high outside WR0/WR1.
- Asynchronous reset mid-job: immediate IDLE, no further writes, job_count cleared.
- job_count wraps from 2^CNT_W-1 to 0 without a flag.

Test Plan:
- Reset, then start pulse at edge 0 with PROD_CYCLES=1 -> busy high cycles 1-5; memWe high cycles 4-5 with memMuxCtrl 1 then 0; result_valid high from cycle 6; job_count=1.
- PROD_CYCLES=4, single job -> all ops=10 for exactly 4 consecutive cycles; result_valid at cycle 9 after start.
- result_ready held low 10 cycles in DONE, then start and result_ready together -> result_valid stays high 10 cycles; SUM follows directly; second job completes; job_count=2.
- abort during MUL -> IDLE next cycle; memWe never high; job_count unchanged. Repeat with abort in WR0 -> exactly one memWe cycle (memMuxCtrl=1), then IDLE.
- Assert reset asynchronously mid-COMB (between clock edges) -> all outputs 0 before the next edge; job_count=0; a fresh start afterwards completes normally.
- CNT_W=2, run 5 jobs -> job_count sequence 1, 2, 3, 0, 1; start pulses issued while busy have no effect.
